fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/cla16.sv | 42 ++++
 rtl/fetch_ctrl.sv | 96 +++++++++
 tb/tb_fetch_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encodings,
// the HALT opcode and the default bubble instruction.
package fetch_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [4:0]  OP_HALT     = 5'b00000;
  localparam logic [15:0] NOP_DEFAULT = 16'h0800;

  function automatic logic is_halt(input logic [15:0] ins);
    return ins[15:11] == OP_HALT;
  endfunction
endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a
// second-level lookahead across the group carries.
module cla16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = A & B;
  assign p = A ^ B;

  // Group generate/propagate, then group carries without rippling.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = Cin;
    gc[1] = gg[0] | (gp[0] & Cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & Cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign Sum  = p ^ c;
  assign Cout = gc[4];
endmodule

// File: rtl/fetch_ctrl.sv
// Sequential fetch controller: owns the architectural PC, issues one
// instruction read at a time and holds the result until writeback commits.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] newPC,
  input  logic        commit,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  input  logic        imemErr,
  output logic [15:0] imemAddr,
  output logic        imemRd,
  output logic [15:0] pc,
  output logic [15:0] nextPC,
  output logic [15:0] instr,
  output logic        instrValid,
  output logic        halted,
  output logic        err
);
  state_e      state_q;
  logic [15:0] pc_q, instr_q;
  logic        valid_q, rd_q, halted_q, err_q;
  logic        pc_cout_unused;

  cla16 u_pc_inc (
    .A   (pc_q),
    .B   (16'h0002),
    .Cin (1'b0),
    .Sum (nextPC),
    .Cout(pc_cout_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RST;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      rd_q     <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          state_q <= S_FETCH;
          rd_q    <= 1'b1;
        end
        S_FETCH: begin
          // Error takes priority over a simultaneous completion.
          if (imemErr) begin
            state_q <= S_ERR;
            rd_q    <= 1'b0;
            err_q   <= 1'b1;
          end else if (imemDone) begin
            state_q <= S_HOLD;
            rd_q    <= 1'b0;
            instr_q <= imemData;
            valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (commit) begin
            pc_q    <= newPC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (is_halt(instr_q)) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_q    <= 1'b1;
            end
          end
        end
        default: begin
          rd_q    <= 1'b0;
          valid_q <= 1'b0;
          instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign imemAddr   = pc_q;
  assign imemRd     = rd_q;
  assign instr      = valid_q ? instr_q : NOP_INSTR;
  assign instrValid = valid_q;
  assign halted     = halted_q;
  assign err        = err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_fetch_ctrl;
  logic        clk, rst;
  logic [15:0] newPC, imemData;
  logic        commit, imemDone, imemErr;
  logic [15:0] imemAddr, pc, nextPC, instr;
  logic        imemRd, instrValid, halted, err;
  int          ntests, nfail;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .newPC(newPC), .commit(commit),
    .imemData(imemData), .imemDone(imemDone), .imemErr(imemErr),
    .imemAddr(imemAddr), .imemRd(imemRd), .pc(pc), .nextPC(nextPC),
    .instr(instr), .instrValid(instrValid), .halted(halted), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Async pulse between edges, then one edge so the FSM leaves RST.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ntests++; if (pc !== 16'h0000) begin nfail++; $display("FAIL rst_pc got %h exp 0000", pc); end
    ntests++; if (nextPC !== 16'h0002) begin nfail++; $display("FAIL rst_nextpc got %h exp 0002", nextPC); end
    ntests++; if (instr !== 16'h0800) begin nfail++; $display("FAIL rst_instr got %h exp 0800", instr); end
    ntests++; if ({imemRd, instrValid, halted, err} !== 4'b0000) begin nfail++; $display("FAIL rst_flags got %b exp 0000", {imemRd, instrValid, halted, err}); end
    rst = 1'b0;
    step();
    ntests++; if (imemRd !== 1'b1) begin nfail++; $display("FAIL fetch_rd got %b exp 1", imemRd); end
    ntests++; if (imemAddr !== 16'h0000) begin nfail++; $display("FAIL fetch_addr got %h exp 0000", imemAddr); end
    step();
    imemDone = 1'b1; imemData = 16'hC001;
    step();
    imemDone = 1'b0;
    ntests++; if (instrValid !== 1'b1) begin nfail++; $display("FAIL fetch_valid got %b exp 1", instrValid); end
    ntests++; if (instr !== 16'hC001) begin nfail++; $display("FAIL fetch_instr got %h exp C001", instr); end
    ntests++; if (nextPC !== 16'h0002) begin nfail++; $display("FAIL fetch_nextpc got %h exp 0002", nextPC); end
    ntests++; if (imemRd !== 1'b0) begin nfail++; $display("FAIL hold_rd got %b exp 0", imemRd); end
  endtask

  task automatic test_commit_redirect();
    newPC = 16'h0040; commit = 1'b1;
    step();
    commit = 1'b0;
    ntests++; if (pc !== 16'h0040) begin nfail++; $display("FAIL redir_pc got %h exp 0040", pc); end
    ntests++; if (imemAddr !== 16'h0040) begin nfail++; $display("FAIL redir_addr got %h exp 0040", imemAddr); end
    ntests++; if (imemRd !== 1'b1) begin nfail++; $display("FAIL redir_rd got %b exp 1", imemRd); end
    ntests++; if (instrValid !== 1'b0) begin nfail++; $display("FAIL redir_valid got %b exp 0", instrValid); end
    ntests++; if (instr !== 16'h0800) begin nfail++; $display("FAIL redir_instr got %h exp 0800", instr); end
  endtask

  task automatic test_wrap_stall();
    imemDone = 1'b1; imemData = 16'h1234;
    step();
    imemDone = 1'b0;
    newPC = 16'hFFFE; commit = 1'b1;
    step();
    commit = 1'b0;
    ntests++; if (pc !== 16'hFFFE) begin nfail++; $display("FAIL wrap_pc got %h exp FFFE", pc); end
    ntests++; if (nextPC !== 16'h0000) begin nfail++; $display("FAIL wrap_nextpc got %h exp 0000", nextPC); end
    for (int i = 0; i < 5; i++) begin
      commit = 1'b1; newPC = 16'h1111;
      step();
      ntests++; if (imemAddr !== 16'hFFFE) begin nfail++; $display("FAIL stall_addr cyc %0d got %h exp FFFE", i, imemAddr); end
      ntests++; if ({imemRd, instrValid} !== 2'b10) begin nfail++; $display("FAIL stall_rd_valid cyc %0d got %b exp 10", i, {imemRd, instrValid}); end
    end
    commit = 1'b0;
  endtask

  task automatic test_halt();
    imemDone = 1'b1; imemData = 16'h0000;
    step();
    imemDone = 1'b0;
    ntests++; if ({instrValid, instr} !== {1'b1, 16'h0000}) begin nfail++; $display("FAIL halt_fetch got %b/%h exp 1/0000", instrValid, instr); end
    newPC = 16'h0012; commit = 1'b1;
    step();
    commit = 1'b0;
    ntests++; if (halted !== 1'b1) begin nfail++; $display("FAIL halt_flag got %b exp 1", halted); end
    ntests++; if (pc !== 16'h0012) begin nfail++; $display("FAIL halt_pc got %h exp 0012", pc); end
    ntests++; if ({imemRd, instrValid, err} !== 3'b000) begin nfail++; $display("FAIL halt_outs got %b exp 000", {imemRd, instrValid, err}); end
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; newPC = 16'h3456; imemDone = 1'b1;
      step();
      ntests++; if ({imemRd, halted, pc} !== {2'b01, 16'h0012}) begin nfail++; $display("FAIL halt_sticky cyc %0d got rd=%b h=%b pc=%h exp 0/1/0012", i, imemRd, halted, pc); end
    end
    commit = 1'b0; imemDone = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ntests++; if ({imemRd, halted, pc} !== {2'b10, 16'h0000}) begin nfail++; $display("FAIL b2b_start got rd=%b h=%b pc=%h exp 1/0/0000", imemRd, halted, pc); end
    imemDone = 1'b1; imemData = 16'h2001;
    step();
    imemDone = 1'b0;
    ntests++; if ({instrValid, instr} !== {1'b1, 16'h2001}) begin nfail++; $display("FAIL b2b_hold got %b/%h exp 1/2001", instrValid, instr); end
    commit = 1'b1; newPC = 16'h0013;
    step();
    commit = 1'b0;
    ntests++; if ({imemRd, imemAddr} !== {1'b1, 16'h0013}) begin nfail++; $display("FAIL b2b_refetch got rd=%b addr=%h exp 1/0013", imemRd, imemAddr); end
    ntests++; if (nextPC !== 16'h0015) begin nfail++; $display("FAIL odd_nextpc got %h exp 0015", nextPC); end
  endtask

  task automatic test_mem_err();
    imemErr = 1'b1; imemDone = 1'b1; imemData = 16'h7777;
    step();
    imemErr = 1'b0; imemDone = 1'b0;
    ntests++; if ({err, instrValid, imemRd} !== 3'b100) begin nfail++; $display("FAIL err_set got %b exp 100", {err, instrValid, imemRd}); end
    ntests++; if (instr !== 16'h0800) begin nfail++; $display("FAIL err_instr got %h exp 0800", instr); end
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; imemDone = 1'b1; newPC = 16'h0100;
      step();
      ntests++; if ({err, imemRd, instrValid, pc} !== {3'b100, 16'h0013}) begin nfail++; $display("FAIL err_sticky cyc %0d got e=%b rd=%b v=%b pc=%h exp 1/0/0/0013", i, err, imemRd, instrValid, pc); end
    end
    commit = 1'b0; imemDone = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ntests++; if ({err, imemRd} !== 2'b01) begin nfail++; $display("FAIL arst_fetch got e=%b rd=%b exp 0/1", err, imemRd); end
    imemDone = 1'b1; imemData = 16'h5555;
    #2;
    rst = 1'b1;
    #1;
    ntests++; if (imemRd !== 1'b0) begin nfail++; $display("FAIL arst_rd_drop got %b exp 0", imemRd); end
    ntests++; if ({pc, nextPC, instr} !== {16'h0000, 16'h0002, 16'h0800}) begin nfail++; $display("FAIL arst_vals got %h/%h/%h exp 0000/0002/0800", pc, nextPC, instr); end
    rst = 1'b0;
    step();
    ntests++; if ({imemRd, instrValid, instr} !== {2'b10, 16'h0800}) begin nfail++; $display("FAIL arst_inflight got rd=%b v=%b i=%h exp 1/0/0800", imemRd, instrValid, instr); end
    imemDone = 1'b0;
  endtask

  initial begin
    ntests = 0; nfail = 0;
    rst = 1'b1; newPC = '0; commit = 1'b0;
    imemData = '0; imemDone = 1'b0; imemErr = 1'b0;
    #12;
    test_reset();
    test_commit_redirect();
    test_wrap_stall();
    test_halt();
    test_back_to_back();
    test_mem_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
